// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one request in flight to instruction memory,
// and presents instruction/PC pairs to decode through an output register plus a one-entry skid buffer.
//
// state | meaning
// ISSUE | no request outstanding; issue one at pc when the skid buffer is empty
// WAIT  | request outstanding; the response belongs to pc
// DROP  | request outstanding but stale after a redirect; its response is discarded
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        slot_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ISSUE;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_pc_q    <= 32'h0;
      out_instr_q <= 32'h0;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= 32'h0;
      buf_instr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    imem_rmask  = 4'h0;

    slot_free = !out_valid_q || !stall;

    if (out_valid_q && !stall) begin
      out_valid_d = 1'b0;
    end

    // Drain first so a response landing this same cycle refills the buffer.
    if (slot_free && buf_valid_q) begin
      out_valid_d = 1'b1;
      out_pc_d    = buf_pc_q;
      out_instr_d = buf_instr_q;
      buf_valid_d = 1'b0;
    end

    case (state_q)
      S_ISSUE: begin
        if (!rst && !redirect_valid && !buf_valid_q) begin
          imem_rmask = 4'hF;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp) begin
          state_d = S_ISSUE;
          pc_d    = pc_q + 32'd4;
          if (slot_free && !buf_valid_q) begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = imem_rdata;
          end else begin
            buf_valid_d = 1'b1;
            buf_pc_d    = pc_q;
            buf_instr_d = imem_rdata;
          end
        end
      end
      S_DROP: begin
        if (imem_resp) begin
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_ISSUE;
    endcase

    // Redirect wins over stall and response; a request still in flight becomes stale.
    if (redirect_valid) begin
      out_valid_d = 1'b0;
      buf_valid_d = 1'b0;
      pc_d        = redirect_pc;
      if (state_q == S_WAIT) begin
        state_d = imem_resp ? S_ISSUE : S_DROP;
      end
    end
  end

  assign imem_addr = pc_q;
  assign id_valid  = out_valid_q;
  assign id_pc     = out_pc_q;
  assign id_instr  = out_instr_q;

endmodule
